// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution control sequencer.
// Holds the FSM state encoding, the default end-of-run marker and an index-width helper.
// No logic lives here; it is imported by the sequencer and its counters.
package conv_pkg;

  // nrows value in an image header that terminates a run
  localparam logic [15:0] END_MARKER_DEFAULT = 16'h00FF;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR_R,
    S_HDR_C,
    S_WDIM,
    S_WGT,
    S_PRIME,
    S_ROW,
    S_COL,
    S_WR,
    S_SKIP,
    S_DONE
  } state_t;

  // Width of an index that counts 0..n-1, never narrower than one bit
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_counter.sv
// Generic up-counter with clear, parallel load, increment and a terminal-value compare.
// Latency: count updates one cycle after the control input; at_term is combinational on the count.
// No backpressure: priority is clear, then load, then increment.
module seq_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_b,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] term_val,
  output logic [W-1:0] cnt,
  output logic         at_term
);

  // Count register: clear wins over load, load wins over increment
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_term = (cnt == term_val);

endmodule

// File: rtl/conv_sequencer.sv
// Control sequencer for the binary-image convolution engine: headers, weights, rows, columns, writes.
// Latency: nrows valid 2 cycles after dut_run; data strobes fire 1 cycle after their address.
// No backpressure: memories answer in fixed time; dut_run is ignored while busy.
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int                ADDR_W     = 12,
  parameter int                DATA_W     = 16,
  parameter int                KMAX       = 5,
  parameter logic [DATA_W-1:0] END_MARKER = DATA_W'(END_MARKER_DEFAULT)
) (
  input  logic                      clk,
  input  logic                      reset_b,
  input  logic                      dut_run,
  output logic                      dut_busy,
  output logic [ADDR_W-1:0]         dut_sram_read_address,
  input  logic [DATA_W-1:0]         sram_dut_read_data,
  output logic [ADDR_W-1:0]         dut_wmem_read_address,
  input  logic [DATA_W-1:0]         wmem_dut_read_data,
  output logic [ADDR_W-1:0]         dut_sram_write_address,
  output logic                      dut_sram_write_enable,
  output logic                      ld_kdim,
  output logic                      ld_wgt,
  output logic [idx_w(KMAX)-1:0]    wgt_idx,
  output logic                      shift_row,
  output logic                      conv_en,
  output logic [idx_w(DATA_W)-1:0]  col_idx,
  output logic                      err_pulse
);

  localparam int WI = idx_w(KMAX);
  localparam int CI = idx_w(DATA_W);

  state_t              state;
  logic [DATA_W-1:0]   nrows;
  logic [DATA_W-1:0]   ncols;
  logic [DATA_W-1:0]   k_reg;

  logic [ADDR_W-1:0]   rd_cnt, wm_cnt, wr_cnt;
  logic [DATA_W-1:0]   row_cnt;
  logic [CI-1:0]       col_cnt;
  logic                wm_term, row_term, col_term;
  logic                rd_term_unused, wr_term_unused;

  logic                rd_clr, rd_load, rd_inc;
  logic                wm_clr, wm_load, wm_inc;
  logic                wr_clr, wr_inc;
  logic                row_clr, row_inc;
  logic                col_clr, col_inc;
  logic [DATA_W-1:0]   row_term_val;

  logic                run_acc;
  logic                hdr_end;
  logic                first_wgt;
  logic [DATA_W-1:0]   k_eff;
  logic                k_bad;

  // K arrives straight from weight memory in the first WGT cycle and is held in k_reg afterwards
  always_comb begin
    run_acc   = (state == S_IDLE) && dut_run;
    hdr_end   = (sram_dut_read_data == END_MARKER);
    first_wgt = (wm_cnt == ADDR_W'(1));
    k_eff     = first_wgt ? wmem_dut_read_data : k_reg;
    k_bad     = (k_eff == '0) || (k_eff > DATA_W'(KMAX)) ||
                (k_eff > nrows) || (k_eff > ncols);
  end

  // Counter controls derived from the current state; the counters themselves are the address registers
  always_comb begin
    rd_clr  = run_acc;
    rd_load = (state == S_SKIP);
    rd_inc  = (state == S_HDR_R) || ((state == S_HDR_C) && !hdr_end) ||
              (state == S_PRIME) || (state == S_ROW);

    wm_clr  = (state == S_HDR_C) && !hdr_end;
    wm_load = (state == S_WDIM);
    wm_inc  = (state == S_WGT) && !k_bad && !wm_term;

    wr_clr  = run_acc;
    wr_inc  = (state == S_WR);

    // Row counter doubles as the priming-read counter; it is idle between the two uses
    row_term_val = (state == S_PRIME) ? (k_reg - DATA_W'(2)) : (nrows - k_reg);
    row_clr      = run_acc || (((state == S_PRIME) || (state == S_WR)) && row_term);
    row_inc      = ((state == S_PRIME) || (state == S_WR)) && !row_term;

    col_clr = (state == S_ROW);
    col_inc = (state == S_COL) && conv_en && !col_term;
  end

  seq_counter #(.W(ADDR_W)) u_rd_cnt (
    .clk      (clk),
    .reset_b  (reset_b),
    .clr      (rd_clr),
    .load     (rd_load),
    .load_val (rd_cnt + ADDR_W'(nrows)),
    .inc      (rd_inc),
    .term_val ('0),
    .cnt      (rd_cnt),
    .at_term  (rd_term_unused)
  );

  seq_counter #(.W(ADDR_W)) u_wm_cnt (
    .clk      (clk),
    .reset_b  (reset_b),
    .clr      (wm_clr),
    .load     (wm_load),
    .load_val (ADDR_W'(1)),
    .inc      (wm_inc),
    .term_val (ADDR_W'(k_eff)),
    .cnt      (wm_cnt),
    .at_term  (wm_term)
  );

  seq_counter #(.W(ADDR_W)) u_wr_cnt (
    .clk      (clk),
    .reset_b  (reset_b),
    .clr      (wr_clr),
    .load     (1'b0),
    .load_val ('0),
    .inc      (wr_inc),
    .term_val ('0),
    .cnt      (wr_cnt),
    .at_term  (wr_term_unused)
  );

  seq_counter #(.W(DATA_W)) u_row_cnt (
    .clk      (clk),
    .reset_b  (reset_b),
    .clr      (row_clr),
    .load     (1'b0),
    .load_val ('0),
    .inc      (row_inc),
    .term_val (row_term_val),
    .cnt      (row_cnt),
    .at_term  (row_term)
  );

  seq_counter #(.W(CI)) u_col_cnt (
    .clk      (clk),
    .reset_b  (reset_b),
    .clr      (col_clr),
    .load     (1'b0),
    .load_val ('0),
    .inc      (col_inc),
    .term_val (CI'(ncols - k_reg)),
    .cnt      (col_cnt),
    .at_term  (col_term)
  );

  assign dut_sram_read_address  = rd_cnt;
  assign dut_wmem_read_address  = wm_cnt;
  assign dut_sram_write_address = wr_cnt;
  assign col_idx                = col_cnt;

  // Sequencer FSM with registered strobes; strobes default low and are raised for exactly one cycle
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state                 <= S_IDLE;
      dut_busy              <= 1'b0;
      nrows                 <= '0;
      ncols                 <= '0;
      k_reg                 <= '0;
      dut_sram_write_enable <= 1'b0;
      ld_kdim               <= 1'b0;
      ld_wgt                <= 1'b0;
      wgt_idx               <= '0;
      shift_row             <= 1'b0;
      conv_en               <= 1'b0;
      err_pulse             <= 1'b0;
    end else begin
      dut_sram_write_enable <= 1'b0;
      ld_kdim               <= 1'b0;
      ld_wgt                <= 1'b0;
      shift_row             <= 1'b0;
      err_pulse             <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dut_run) begin
            dut_busy <= 1'b1;
            state    <= S_HDR_R;
          end
        end
        S_HDR_R: state <= S_HDR_C;
        S_HDR_C: begin
          nrows <= sram_dut_read_data;
          state <= hdr_end ? S_DONE : S_WDIM;
        end
        S_WDIM: begin
          ncols   <= sram_dut_read_data;
          ld_kdim <= 1'b1;
          state   <= S_WGT;
        end
        S_WGT: begin
          if (first_wgt) begin
            k_reg <= wmem_dut_read_data;
          end
          if (k_bad) begin
            err_pulse <= 1'b1;
            state     <= S_SKIP;
          end else begin
            ld_wgt  <= 1'b1;
            wgt_idx <= WI'(wm_cnt - 1'b1);
            if (wm_term) begin
              state <= (k_eff == DATA_W'(1)) ? S_ROW : S_PRIME;
            end
          end
        end
        S_PRIME: begin
          shift_row <= 1'b1;
          if (row_term) begin
            state <= S_ROW;
          end
        end
        S_ROW: begin
          shift_row <= 1'b1;
          conv_en   <= 1'b0;
          state     <= S_COL;
        end
        S_COL: begin
          // First COL cycle is the bubble in which the new row is shifted in
          if (!conv_en) begin
            conv_en <= 1'b1;
          end else if (col_term) begin
            conv_en               <= 1'b0;
            dut_sram_write_enable <= 1'b1;
            state                 <= S_WR;
          end
        end
        S_WR:    state <= row_term ? S_HDR_R : S_ROW;
        S_SKIP:  state <= S_HDR_R;
        S_DONE: begin
          dut_busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/conv_sequencer.md
# conv_sequencer

Parametrised control sequencer for the binary-image convolution engine. It streams any number of images from input SRAM until an end marker appears. It supports any square kernel from 1×1 to KMAX×KMAX. It drives SRAM and weight-memory addresses directly and issues strobes to the convolution datapath, which holds the line buffer, weight registers and MAC array. It replaces the fixed 3×3 controller and its external address/row/column counters.

## Interface
Parameters:
- ADDR_W, 12, address width of input SRAM, weight memory and output SRAM
- DATA_W, 16, word width; one word holds one image row (bit c = column c), so ncols ≤ DATA_W
- KMAX, 5, largest supported kernel dimension (1..DATA_W)
- END_MARKER, 16'h00FF, nrows value that terminates a run

Ports:
- clk  in  1  clock
- reset_b  in  1  asynchronous, active-low reset
- dut_run  in  1  start pulse/level, sampled only in IDLE
- dut_busy  out  1  high from the cycle after run is accepted until DONE
- dut_sram_read_address  out  ADDR_W  input SRAM address, registered
- sram_dut_read_data  in  DATA_W  input data, valid 1 cycle after address
- dut_wmem_read_address  out  ADDR_W  weight memory address, registered
- wmem_dut_read_data  in  DATA_W  weight data, valid 1 cycle after address
- dut_sram_write_address  out  ADDR_W  output row address
- dut_sram_write_enable  out  1  write strobe (datapath supplies write data)
- ld_kdim / ld_wgt  out  1  capture K / capture weight row wgt_idx
- wgt_idx  out  $clog2(KMAX)  weight row index
- shift_row  out  1  shift current read word into line buffer
- conv_en  out  1  compute output pixel at col_idx
- col_idx  out  $clog2(DATA_W)  leftmost column of the current window
- err_pulse  out  1  one-cycle pulse when an image is rejected

## Operation
- State machine: IDLE → HDR_R → HDR_C → WDIM → WGT → PRIME → ROW → COL → WR, then ROW or HDR_R. SKIP and DONE are side exits.
- IDLE: waits for dut_run. On accept: read address ← 0, write address ← 0 and dut_busy rises next cycle. dut_run is ignored whenever busy.
- HDR_R / HDR_C: read nrows, then ncols; the read address advances each read.
  - nrows == END_MARKER → DONE.
  - DONE: dut_busy low next cycle, then IDLE.
- WDIM: weight address ← 0, read K; ld_kdim.
- WGT: reads K weight rows at weight addresses 1..K; ld_wgt with wgt_idx 0..K-1.
  - Weights are reloaded per image.
- Validation after WDIM: reject the image if K == 0, K > KMAX, K > nrows or K > ncols.
  - Reject action: err_pulse, then SKIP.
  - SKIP: read address ← read address + nrows with no reads and no writes, then HDR_R.
- PRIME: reads K-1 rows, one shift_row each.
- ROW: reads one row, shift_row.
- COL: conv_en for col_idx = 0..ncols-K, one per cycle.
- WR: dut_sram_write_enable for one cycle at the current write address, then write address +1. Output row counter +1.
  - Counter == nrows-K+1 → HDR_R (next image header is the next read address).
  - Otherwise → ROW.
- Output per image: (nrows-K+1) rows of (ncols-K+1) valid bits. Rows are written contiguously across images with no header.
- Arithmetic: dimension compares are done in DATA_W bits. Addresses wrap modulo 2^ADDR_W silently.

## Timing
- Reset values:
  - Output/strobe signals: all outputs 0, state IDLE. Covers dut_busy, both read addresses, write address, wgt_idx, col_idx and every strobe (dut_sram_write_enable, ld_kdim, ld_wgt, shift_row, conv_en, err_pulse).
  - Counters: all counters 0.
- Reset mid-run: immediate return to IDLE with all outputs 0. No write is completed after reset_b falls.
- Every data strobe (ld_kdim, ld_wgt, shift_row) is asserted in the cycle its data is valid, i.e. 1 cycle after the matching address.
- Reads within a phase are issued back-to-back, one per cycle.
- Start latency: dut_run in IDLE at cycle t → read address 0 at t+1 → nrows valid at t+2.
- conv_en for the last column and the WR strobe are in consecutive cycles.
- Cycles per output row: 1 (ROW) + (ncols-K+1) (COL) + 1 (WR), plus a 1-cycle read bubble.
- Edge cases:
  - K == 1: PRIME is empty.
  - ncols == K: one conv_en per row.
  - nrows == K: exactly one output row.

## Structure
- conv_pkg: state enum, END_MARKER default, helper for the $clog2 width.
- One sub-module, seq_counter (load/increment/terminal-compare counter). Instantiated for read address, weight address, write address, row counter and column counter.
- The FSM stays in conv_sequencer. Outputs are registered.

## Test plan
- Reset mid-run: assert reset_b low during COL of a 4×4 image → all outputs 0 next edge. A later dut_run restarts from read address 0.
- One image then end: 4×4 image, K=3, then nrows=00FF.
  - Writes at addresses 0 and 1 only.
  - conv_en with col_idx 0,1 per row.
  - dut_busy falls after DONE.
- Back-to-back images: 5×6 K=3 then 3×3 K=3 → write addresses 0,1,2 then 3. The second header is read at address 7.
- Largest kernel: 5×5 image, K=5 → one WR, single conv_en at col_idx 0, PRIME issues 4 shift_rows.
- Rejected image: K=4, nrows=3 → err_pulse, no writes. The next header is read at address 2+3=5 and processed normally.
- Immediate end: nrows=00FF at address 0 → no writes, no weight reads. dut_busy high for the HDR_R/DONE cycles only.
